// File: rtl/line_fill_unit.sv
// Cache line refill engine: fetches one line as single-word beats, critical word first
// with wrap-around, forwards the critical word early and strobes the assembled line.
module line_fill_unit #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 32,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              fill_busy,
  output logic              crit_valid,
  output logic [BEAT_W-1:0] crit_data,
  output logic              fill_done,
  output logic [LINE_W-1:0] fill_line,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int IDX_W  = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int LANE_W = $clog2(BEAT_W / 8);
  localparam int BASE_W = ADDR_W - OFF_W;

  // Handshake: a beat transfers on any rising edge where mem_req && mem_ack are both
  // high; mem_rdata is valid in that same cycle. mem_addr only moves after a transfer.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [BASE_W-1:0] base;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [IDX_W-1:0]  count, count_nx;
  logic              unused_lane;

  assign unused_lane = ^fill_addr[LANE_W-1:0];
  assign idx_nx      = idx + IDX_W'(1);
  assign count_nx    = count + IDX_W'(1);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fill_req) state_nx = FETCH;
      FETCH:   if (mem_ack && count == IDX_W'(BEATS - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    fill_busy = 1'b0;
    mem_req   = 1'b0;
    fill_done = 1'b0;
    case (state)
      FETCH: begin
        fill_busy = 1'b1;
        mem_req   = 1'b1;
      end
      DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: request capture, beat placement by slot index, critical-word forwarding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base       <= '0;
      idx        <= '0;
      count      <= '0;
      mem_addr   <= '0;
      fill_line  <= '0;
      crit_data  <= '0;
      crit_valid <= 1'b0;
    end else begin
      crit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_req) begin
            base     <= fill_addr[ADDR_W-1:OFF_W];
            idx      <= fill_addr[OFF_W-1:LANE_W];
            count    <= '0;
            mem_addr <= {fill_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          end
        end
        FETCH: begin
          if (mem_ack) begin
            for (int w = 0; w < BEATS; w++) begin
              if (idx == IDX_W'(w)) fill_line[w*BEAT_W +: BEAT_W] <= mem_rdata;
            end
            idx      <= idx_nx;
            count    <= count_nx;
            mem_addr <= {base, idx_nx, {LANE_W{1'b0}}};
            if (count == '0) begin
              crit_data  <= mem_rdata;
              crit_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
